s_axi_regfile: RTL and testbench

- Parametrised AXI slave register file; next generation of the team's fixed 6×32-bit AXI register block.
- Adds the following over that block: generic data width, register count and ID width; AW/W channels accepted independently in either order; ID echo on B and R; SLVERR responses; per-register bus read-only mask; per-register hardware update port.
- Sits between the AXI interconnect and core logic (counter control/status), exposing all registers in parallel.

---
 rtl/s_axi_regfile.sv | 203 ++++++++++++++++++++
 tb/tb_s_axi_regfile.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_axi_regfile.sv
// AXI slave register file: REG_COUNT registers of DATA_WIDTH bits, single-beat
// accesses, independent AW/W acceptance, SLVERR for out-of-range or read-only
// writes, and a per-register hardware load port that competes with bus writes.
module s_axi_regfile #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   ID_WIDTH   = 4,
  parameter int                   REG_COUNT  = 8,
  parameter logic [REG_COUNT-1:0] RO_MASK    = '0
) (
  input  logic                    clk,
  input  logic                    areset,
  // register view towards core logic
  output logic [DATA_WIDTH-1:0]   regs_o [REG_COUNT],
  input  logic [REG_COUNT-1:0]    hw_we_i,
  input  logic [DATA_WIDTH-1:0]   hw_wdata_i [REG_COUNT],
  // write address channel
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  // write response channel
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  // read address channel
  input  logic [ID_WIDTH-1:0]     arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  // read data channel
  output logic [ID_WIDTH-1:0]     rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);

  localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int         ADDR_LSB    = $clog2(STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

  // one-entry holding registers for the AW and W channels
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic aw_held_d, w_held_d, bvalid_d;

  logic [ADDR_WIDTH-1:0] wr_index, rd_index;
  logic [REG_COUNT-1:0]  wr_sel, rd_sel;
  logic                  wr_ok, rd_in_range;
  logic [DATA_WIDTH-1:0] rd_value;

  // Single-beat only: wlast carries no information here.
  logic unused_wlast;
  assign unused_wlast = wlast_i;

  assign aw_hs  = awvalid_i && awready_o;
  assign w_hs   = wvalid_i && wready_o;
  assign b_hs   = bvalid_o && bready_i;
  assign ar_hs  = arvalid_i && arready_o;
  assign r_hs   = rvalid_o && rready_i;
  assign commit = aw_held && w_held;

  // Word index uses every upper address bit, so aliases above REG_COUNT miss.
  assign wr_index = aw_addr_q >> ADDR_LSB;
  assign rd_index = araddr_i >> ADDR_LSB;

  // One-hot register select for the held write address and the live read address.
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      wr_sel[i] = (wr_index == ADDR_WIDTH'(i));
      rd_sel[i] = (rd_index == ADDR_WIDTH'(i));
    end
  end

  // A write lands only on an in-range, bus-writable register.
  assign wr_ok       = |(wr_sel & ~RO_MASK);
  assign rd_in_range = |rd_sel;

  // Read mux; an out-of-range index selects nothing and yields zero.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise a path that skips it infers a latch.
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (rd_sel[i]) rd_value = rd_value | regs_q[i];
    end
  end

  // Next register values: hardware load first, then strobed bus bytes on top.
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = hw_we_i[i] ? hw_wdata_i[i] : regs_q[i];
      if (commit && wr_sel[i] && !RO_MASK[i]) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (w_strb_q[b]) regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
        end
      end
    end
  end

  // Next-state of the write holding flags and the response valid.
  always_comb begin
    aw_held_d = commit ? 1'b0 : (aw_held || aw_hs);
    w_held_d  = commit ? 1'b0 : (w_held || w_hs);
    bvalid_d  = commit || (bvalid_o && !bready_i);
  end

  // Register storage.
  // NOTE: these are individual flops, not a RAM macro, so resetting the whole
  // array is cheap and gives core logic a defined value from the first cycle.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign regs_o = regs_q;

  // Write path: capture AW/W independently, commit when both are held,
  // and hold the response until the master accepts it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      aw_id_q   <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_o <= 1'b1;
      wready_o  <= 1'b1;
      bvalid_o  <= 1'b0;
      bid_o     <= '0;
      bresp_o   <= RESP_OKAY;
    end else begin
      aw_held   <= aw_held_d;
      w_held    <= w_held_d;
      bvalid_o  <= bvalid_d;
      awready_o <= !aw_held_d && !bvalid_d;
      wready_o  <= !w_held_d && !bvalid_d;
      if (aw_hs) begin
        aw_addr_q <= awaddr_i;
        aw_id_q   <= awid_i;
      end
      if (w_hs) begin
        w_data_q <= wdata_i;
        w_strb_q <= wstrb_i;
      end
      if (commit) begin
        bid_o   <= aw_id_q;
        bresp_o <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bid_o   <= '0;
        bresp_o <= RESP_OKAY;
      end
    end
  end

  // Read path: capture the pre-edge register value on AR, hold until R accepted.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      arready_o <= 1'b1;
      rvalid_o  <= 1'b0;
      rlast_o   <= 1'b0;
      rid_o     <= '0;
      rdata_o   <= '0;
      rresp_o   <= RESP_OKAY;
    end else if (ar_hs) begin
      arready_o <= 1'b0;
      rvalid_o  <= 1'b1;
      rlast_o   <= 1'b1;
      rid_o     <= arid_i;
      rdata_o   <= rd_value;
      rresp_o   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs) begin
      arready_o <= 1'b1;
      rvalid_o  <= 1'b0;
      rlast_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_s_axi_regfile.sv
// Self-checking bench for s_axi_regfile: directed scenarios followed by random
// traffic, all compared against an array-based model of the register file.
module tb_s_axi_regfile;

  localparam int             DW = 32;
  localparam int             AW = 32;
  localparam int             IW = 4;
  localparam int             RC = 8;
  localparam logic [RC-1:0]  RO = 8'h02;

  logic          clk = 1'b0;
  logic          areset;
  logic [DW-1:0] regs_o [RC];
  logic [RC-1:0] hw_we_i;
  logic [DW-1:0] hw_wdata_i [RC];
  logic [IW-1:0] awid_i;
  logic [AW-1:0] awaddr_i;
  logic          awvalid_i, awready_o;
  logic [DW-1:0] wdata_i;
  logic [3:0]    wstrb_i;
  logic          wlast_i, wvalid_i, wready_o;
  logic [IW-1:0] bid_o;
  logic [1:0]    bresp_o;
  logic          bvalid_o, bready_i;
  logic [IW-1:0] arid_i;
  logic [AW-1:0] araddr_i;
  logic          arvalid_i, arready_o;
  logic [IW-1:0] rid_o;
  logic [DW-1:0] rdata_o;
  logic [1:0]    rresp_o;
  logic          rlast_o, rvalid_o, rready_i;

  always #5 clk = ~clk;

  s_axi_regfile #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .REG_COUNT(RC), .RO_MASK(RO)
  ) dut (
    .clk(clk), .areset(areset), .regs_o(regs_o), .hw_we_i(hw_we_i), .hw_wdata_i(hw_wdata_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o),
    .rready_i(rready_i)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_regs [RC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] bus,
                                        input logic [3:0] strb);
    logic [31:0] m;
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (base & ~m) | (bus & m);
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int unsigned idx;
    idx = addr / 4;
    if (idx < RC && RO[idx] == 1'b0) begin
      exp_regs[idx] = merge(exp_regs[idx], data, strb);
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int unsigned idx;
    idx = addr / 4;
    if (idx < RC) begin
      data = exp_regs[idx];
      resp = 2'b00;
    end else begin
      data = 32'h0;
      resp = 2'b10;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check_all_regs(input string tag);
    for (int i = 0; i < RC; i++) check($sformatf("%s_reg%0d", tag, i), regs_o[i], exp_regs[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, awready_o, 1);
    check({tag, "_wready"},  wready_o,  1);
    check({tag, "_arready"}, arready_o, 1);
    check({tag, "_bvalid"},  bvalid_o,  0);
    check({tag, "_rvalid"},  rvalid_o,  0);
    check({tag, "_bid"},     bid_o,     0);
    check({tag, "_rid"},     rid_o,     0);
    check({tag, "_rdata"},   rdata_o,   0);
    check({tag, "_rresp"},   rresp_o,   0);
    check({tag, "_bresp"},   bresp_o,   0);
    check({tag, "_rlast"},   rlast_o,   0);
  endtask

  // Wait for B, optionally stall bready, then accept it.
  task automatic b_accept(input int stall, output logic [1:0] resp, output logic [IW-1:0] id);
    int n = 0;
    while (!bvalid_o && n < 20) begin
      tick();
      n++;
    end
    check("b_wait", bvalid_o, 1);
    resp = bresp_o;
    id   = bid_o;
    for (int k = 0; k < stall; k++) begin
      tick();
      check("b_stable_valid", bvalid_o, 1);
      check("b_stable_id", bid_o, id);
    end
    bready_i = 1'b1;
    tick();
    bready_i = 1'b0;
    check("b_clear", bvalid_o, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [IW-1:0] id,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_stall);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    logic [1:0] resp, exp_resp;
    logic [IW-1:0] got_id;
    awaddr_i = addr; awid_i = id; wdata_i = data; wstrb_i = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid_i = !aw_done && cyc >= aw_dly;
      wvalid_i  = !w_done && cyc >= w_dly;
      aw_hs = awvalid_i && awready_o;
      w_hs  = wvalid_i && wready_o;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    awvalid_i = 1'b0;
    wvalid_i  = 1'b0;
    check("wr_accept", {aw_done, w_done}, 2'b11);
    b_accept(b_stall, resp, got_id);
    exp_resp = model_write(addr, data, strb);
    check($sformatf("wr_bresp_a%0h", addr), resp, exp_resp);
    check("wr_bid", got_id, id);
    check_all_regs("wr");
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [IW-1:0] id);
    int n = 0;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    araddr_i = addr; arid_i = id; arvalid_i = 1'b1;
    while (!arready_o && n < 20) begin
      tick();
      n++;
    end
    check("ar_ready", arready_o, 1);
    tick();
    arvalid_i = 1'b0;
    model_read(addr, exp_data, exp_resp);
    check("rd_rvalid", rvalid_o, 1);
    check($sformatf("rd_rdata_a%0h", addr), rdata_o, exp_data);
    check($sformatf("rd_rresp_a%0h", addr), rresp_o, exp_resp);
    check("rd_rid", rid_o, id);
    check("rd_rlast", rlast_o, 1);
    check("rd_arready_busy", arready_o, 0);
    rready_i = 1'b1;
    tick();
    rready_i = 1'b0;
    check("rd_rvalid_clr", rvalid_o, 0);
    check("rd_rlast_clr", rlast_o, 0);
    check("rd_arready_back", arready_o, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    logic [IW-1:0] id;

    areset = 1'b0;
    hw_we_i = '0;
    for (int i = 0; i < RC; i++) begin
      hw_wdata_i[i] = '0;
      exp_regs[i] = '0;
    end
    awid_i = '0; awaddr_i = '0; awvalid_i = 0;
    wdata_i = '0; wstrb_i = '0; wlast_i = 1'b1; wvalid_i = 0; bready_i = 0;
    arid_i = '0; araddr_i = '0; arvalid_i = 0; rready_i = 0;

    // ---- reset state ----
    repeat (3) tick();
    check_reset_outputs("rst");
    areset = 1'b1;
    tick();
    check_reset_outputs("post_rst");
    check_all_regs("post_rst");

    // ---- same-cycle AW+W, B two cycles later, then read back ----
    awaddr_i = 32'h08; awid_i = 4'd3; awvalid_i = 1;
    wdata_i = 32'hDEADBEEF; wstrb_i = 4'hF; wvalid_i = 1;
    tick();
    awvalid_i = 0; wvalid_i = 0;
    check("tp1_bvalid_early", bvalid_o, 0);
    check("tp1_awready_held", awready_o, 0);
    tick();
    check("tp1_bvalid", bvalid_o, 1);
    check("tp1_bid", bid_o, 3);
    check("tp1_bresp", bresp_o, 0);
    resp = model_write(32'h08, 32'hDEADBEEF, 4'hF);
    check("tp1_reg2", regs_o[2], exp_regs[2]);
    bready_i = 1; tick(); bready_i = 0;
    check("tp1_bvalid_clr", bvalid_o, 0);
    check("tp1_awready_back", awready_o, 1);
    check("tp1_wready_back", wready_o, 1);
    do_read(32'h08, 4'd5);

    // ---- W three cycles before AW, partial strobe ----
    do_write(32'h0C, 4'd0, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    wdata_i = 32'h11223344; wstrb_i = 4'h5; wvalid_i = 1;
    tick();
    wvalid_i = 0;
    check("tp2_wready_low", wready_o, 0);
    check("tp2_awready_high", awready_o, 1);
    tick(); tick();
    check("tp2_wready_still_low", wready_o, 0);
    check("tp2_no_b_yet", bvalid_o, 0);
    awaddr_i = 32'h0C; awid_i = 4'd9; awvalid_i = 1;
    tick();
    awvalid_i = 0;
    check("tp2_bvalid_not_yet", bvalid_o, 0);
    tick();
    check("tp2_bvalid", bvalid_o, 1);
    check("tp2_bresp", bresp_o, 0);
    check("tp2_bid", bid_o, 9);
    resp = model_write(32'h0C, 32'h11223344, 4'h5);
    check("tp2_reg3", regs_o[3], 32'hFF22FF44);
    bready_i = 1; tick(); bready_i = 0;
    repeat (3) begin
      tick();
      check("tp2_single_b", bvalid_o, 0);
    end

    // ---- out-of-range write and read ----
    do_write(32'h20, 4'd1, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
    do_read(32'h24, 4'd2);

    // ---- read-only register: bus write rejected, hardware load accepted ----
    do_write(32'h04, 4'd4, 32'h0000AAAA, 4'hF, 0, 0, 0);
    hw_we_i[1] = 1'b1; hw_wdata_i[1] = 32'h1234;
    tick();
    hw_we_i[1] = 1'b0;
    exp_regs[1] = 32'h1234;
    check("tp4_hw_reg1", regs_o[1], exp_regs[1]);
    do_read(32'h04, 4'd6);

    // ---- B stalled five cycles while a second write waits ----
    awaddr_i = 32'h10; awid_i = 4'd7; awvalid_i = 1;
    wdata_i = 32'h0BADF00D; wstrb_i = 4'hF; wvalid_i = 1;
    tick();
    awvalid_i = 0; wvalid_i = 0;
    tick();
    check("tp5_bvalid", bvalid_o, 1);
    resp = model_write(32'h10, 32'h0BADF00D, 4'hF);
    awaddr_i = 32'h14; awid_i = 4'd8; awvalid_i = 1;
    wdata_i = 32'h600DCAFE; wstrb_i = 4'hF; wvalid_i = 1;
    for (int k = 0; k < 5; k++) begin
      check("tp5_bvalid_hold", bvalid_o, 1);
      check("tp5_bid_hold", bid_o, 7);
      check("tp5_bresp_hold", bresp_o, 0);
      check("tp5_awready_low", awready_o, 0);
      check("tp5_wready_low", wready_o, 0);
      tick();
    end
    check("tp5_awready_hs_cycle", awready_o, 0);
    bready_i = 1; tick(); bready_i = 0;
    check("tp5_bvalid_clr", bvalid_o, 0);
    check("tp5_awready_after_b", awready_o, 1);
    tick();
    awvalid_i = 0; wvalid_i = 0;
    check("tp5_second_aw_taken", awready_o, 0);
    check_all_regs("tp5_first");
    b_accept(0, resp, id);
    check("tp5_second_bid", id, 8);
    check("tp5_second_bresp", resp, model_write(32'h14, 32'h600DCAFE, 4'hF));
    check_all_regs("tp5_second");

    // ---- commit, hardware load and read to reg0 on the same edge ----
    do_write(32'h00, 4'd1, 32'h55667788, 4'hF, 0, 0, 0);
    awaddr_i = 32'h00; awid_i = 4'd2; awvalid_i = 1;
    wdata_i = 32'h0000ABCD; wstrb_i = 4'h3; wvalid_i = 1;
    tick();
    awvalid_i = 0; wvalid_i = 0;
    hw_we_i[0] = 1'b1; hw_wdata_i[0] = 32'h99999999;
    araddr_i = 32'h00; arid_i = 4'd2; arvalid_i = 1;
    check("tp6_arready", arready_o, 1);
    tick();
    hw_we_i[0] = 1'b0; arvalid_i = 0;
    exp_regs[0] = merge(32'h99999999, 32'h0000ABCD, 4'h3);
    check("tp6_reg0", regs_o[0], 32'h9999ABCD);
    check("tp6_reg0_model", regs_o[0], exp_regs[0]);
    check("tp6_bvalid", bvalid_o, 1);
    check("tp6_bresp", bresp_o, 0);
    check("tp6_rvalid", rvalid_o, 1);
    check("tp6_rdata_pre_edge", rdata_o, 32'h55667788);
    check("tp6_rid", rid_o, 2);
    rready_i = 1; tick(); rready_i = 0;
    b_accept(0, resp, id);
    check("tp6_b_id", id, 2);

    // ---- reset while B is pending ----
    awaddr_i = 32'h18; awid_i = 4'd5; awvalid_i = 1;
    wdata_i = 32'h12345678; wstrb_i = 4'hF; wvalid_i = 1;
    tick();
    awvalid_i = 0; wvalid_i = 0;
    tick();
    check("rst_b_pending", bvalid_o, 1);
    #2 areset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    for (int i = 0; i < RC; i++) exp_regs[i] = '0;
    check_all_regs("mid_rst");
    tick(); tick();
    areset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_stale_b", bvalid_o, 0);
    end
    check_all_regs("after_rst");

    // ---- random traffic ----
    for (int it = 0; it < 80; it++) begin
      int unsigned op;
      logic [31:0] addr;
      op   = $urandom_range(0, 9);
      addr = ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
      if (op < 5) begin
        do_write(addr, IW'($urandom), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end else if (op < 8) begin
        do_read(addr, IW'($urandom));
      end else begin
        int unsigned idx;
        logic [31:0] d;
        idx = $urandom_range(0, RC - 1);
        d   = $urandom;
        hw_we_i[idx] = 1'b1; hw_wdata_i[idx] = d;
        tick();
        hw_we_i[idx] = 1'b0;
        exp_regs[idx] = d;
        check($sformatf("rnd_hw_reg%0d", idx), regs_o[idx], exp_regs[idx]);
      end
    end
    check_all_regs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
